// File: rtl/mem_stage_writer.sv
// MEM-stage writer: turns EXE/MEM write flags into WOM valid/ready beats (single or 4-beat burst); DRAIN_ADDR_CHECK_EN drops out-of-range beats.
// Latency: the first beat is requested 1 clock after capture; back-to-back commands run with no idle bubble.
// Backpressure: stall holds the pipeline while beats are pending and drops in the cycle the final beat is accepted.
module mem_stage_writer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int PXL_W  = 8
`ifdef DRAIN_ADDR_CHECK_EN
  ,
  parameter logic [63:0] ADDR_LIMIT = 64'h1_0000
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_pxl,
  input  logic              wr_pos,
  input  logic              wr_mul_reg,
  input  logic              wr_wom,
  input  logic              wr_mul_pos,
  input  logic [31:0]       i,
  input  logic [31:0]       j,
  input  logic [31:0]       n,
  input  logic [31:0]       wom_addr,
  input  logic [31:0]       r1,
  input  logic [31:0]       r2,
  input  logic [31:0]       r3,
  input  logic [31:0]       r4,
  output logic              stall,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic [31:0]       pos_i,
  output logic [31:0]       pos_j,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, SINGLE, BURST} state_t;

  state_t            state, state_nxt;
  logic [1:0]        beat;
  logic [ADDR_W-1:0] base;
  logic [31:0]       dat_q [4];
  logic [31:0]       cap_q [4];
  logic [31:0]       cap_addr;
  logic [31:0]       pxl_addr;
  logic [31:0]       pxl_dat;
  logic              cmd_any, is_burst, accept;
  logic              last_beat, beat_done, final_done, addr_bad;

  assign cmd_any   = wr_pxl | wr_wom | wr_mul_reg | wr_mul_pos;
  assign is_burst  = wr_mul_reg | wr_mul_pos;
  assign accept    = cmd_any & ~stall;
  assign pxl_addr  = wom_addr + i * n + j;
  assign pxl_dat   = 32'(r1[PXL_W-1:0]);

  // Beat 0 of every command plus the rest of a burst, in issue order.
  always_comb begin
    cap_q    = '{r1, r2, r3, r4};
    cap_addr = wom_addr;
    if (wr_mul_reg) begin
      cap_q = '{r1, r2, r3, r4};
    end else if (wr_mul_pos) begin
      cap_q = '{i, j, n, r1};
    end else if (!wr_wom && wr_pxl) begin
      cap_addr = pxl_addr;
      cap_q[0] = pxl_dat;
    end
  end

`ifdef DRAIN_ADDR_CHECK_EN
  logic err_q;
  assign addr_bad = (state != IDLE) && (64'(mem_addr) >= ADDR_LIMIT);
  assign err      = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          err_q <= 1'b0;
    else if (addr_bad) err_q <= 1'b1;
  end
`else
  assign addr_bad = 1'b0;
  assign err      = 1'b0;
`endif

  // A suppressed beat counts as accepted without waiting for mem_ready.
  assign beat_done  = (state != IDLE) & (addr_bad | mem_ready);
  assign last_beat  = (state == SINGLE) || ((state == BURST) && (beat == 2'd3));
  assign final_done = beat_done & last_beat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept)          state_nxt = is_burst ? BURST : SINGLE;
    else if (final_done) state_nxt = IDLE;
  end

  always_comb begin
    busy      = 1'b0;
    mem_valid = 1'b0;
    stall     = 1'b0;
    if (state != IDLE) begin
      busy      = 1'b1;
      mem_valid = ~addr_bad;
      stall     = ~final_done;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat      <= 2'd0;
      base      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      pos_i     <= '0;
      pos_j     <= '0;
      for (int k = 0; k < 4; k++) dat_q[k] <= '0;
    end else begin
      if (wr_pos && !stall) begin
        pos_i <= i;
        pos_j <= j;
      end
      if (accept) begin
        beat      <= 2'd0;
        base      <= wom_addr[ADDR_W-1:0];
        mem_addr  <= cap_addr[ADDR_W-1:0];
        mem_wdata <= cap_q[0][DATA_W-1:0];
        dat_q     <= cap_q;
      end else if (beat_done && (state == BURST) && (beat != 2'd3)) begin
        beat      <= beat + 2'd1;
        mem_addr  <= base + ADDR_W'(beat + 2'd1);
        mem_wdata <= dat_q[beat + 2'd1][DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_writer.sv
// Randomized self-checking bench for mem_stage_writer against a beat-queue reference model.
module tb_mem_stage_writer;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] dat;
    bit          bad;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_pxl = 1'b0, wr_pos = 1'b0, wr_mul_reg = 1'b0, wr_wom = 1'b0, wr_mul_pos = 1'b0;
  logic [31:0] i = '0, j = '0, n = '0, wom_addr = '0;
  logic [31:0] r1 = '0, r2 = '0, r3 = '0, r4 = '0;
  logic        mem_ready = 1'b0;
  logic        stall, mem_valid, busy, err;
  logic [31:0] mem_addr, mem_wdata, pos_i, pos_j;

  int          n_chk = 0;
  int          n_pass = 0;
  int          dut_hs = 0;
  int          exp_hs = 0;
  int          hs0;
  beat_t       q[$];
  logic [31:0] exp_pi = '0, exp_pj = '0;
  bit          exp_err = 1'b0;
  bit          pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

`ifdef DRAIN_ADDR_CHECK_EN
  localparam logic [63:0] LIMIT = 64'h102;
`endif

  always #5 clk = ~clk;

  mem_stage_writer #(
`ifdef DRAIN_ADDR_CHECK_EN
    .ADDR_LIMIT(LIMIT)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .wr_pxl(wr_pxl), .wr_pos(wr_pos), .wr_mul_reg(wr_mul_reg), .wr_wom(wr_wom), .wr_mul_pos(wr_mul_pos),
    .i(i), .j(j), .n(n), .wom_addr(wom_addr),
    .r1(r1), .r2(r2), .r3(r3), .r4(r4),
    .stall(stall), .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .pos_i(pos_i), .pos_j(pos_j), .busy(busy), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic bit over_limit(input logic [31:0] a);
`ifdef DRAIN_ADDR_CHECK_EN
    return 64'(a) >= LIMIT;
`else
    return (a != a);
`endif
  endfunction

  // Queue up the beats the winning command must produce, in order.
  function automatic void push_cmd();
    beat_t       b;
    logic [31:0] d [4];
    if (wr_mul_reg || wr_mul_pos) begin
      if (wr_mul_reg) begin d[0] = r1; d[1] = r2; d[2] = r3; d[3] = r4; end
      else            begin d[0] = i;  d[1] = j;  d[2] = n;  d[3] = r1; end
      for (int k = 0; k < 4; k++) begin
        b.addr = wom_addr + 32'(k);
        b.dat  = d[k];
        b.bad  = over_limit(b.addr);
        q.push_back(b);
      end
    end else if (wr_wom || wr_pxl) begin
      b.addr = wr_wom ? wom_addr : wom_addr + i * n + j;
      b.dat  = wr_wom ? r1 : r1 % 256;
      b.bad  = over_limit(b.addr);
      q.push_back(b);
    end
  endfunction

  function automatic bit model_stall();
    if (q.size() == 0) return 1'b0;
    return !(q.size() == 1 && (mem_ready || q[0].bad));
  endfunction

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    bit st;
    bit vld;
    #1;
    st  = model_stall();
    vld = (q.size() > 0) && !q[0].bad;
    check("mem_valid", mem_valid, vld);
    check("stall", stall, st);
    check("busy", busy, q.size() > 0);
    if (vld) begin
      check("mem_addr", mem_addr, q[0].addr);
      check("mem_wdata", mem_wdata, q[0].dat);
    end
    check("pos_i", pos_i, exp_pi);
    check("pos_j", pos_j, exp_pj);
    check("err", err, exp_err);
    if (mem_valid && mem_ready) dut_hs++;
    @(posedge clk);
    if (q.size() > 0 && (mem_ready || q[0].bad)) begin
      if (q[0].bad) exp_err = 1'b1;
      else          exp_hs++;
      q.delete(0);
    end
    if (!st && wr_pos) begin
      exp_pi = i;
      exp_pj = j;
    end
    if (!st) push_cmd();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    q.delete();
    exp_pi  = '0;
    exp_pj  = '0;
    exp_err = 1'b0;
    check("rst_valid", mem_valid, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_pos_i", pos_i, 0);
    check("rst_pos_j", pos_j, 0);
    check("rst_err", err, 0);
    check("rst_stall", stall, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic clear_flags();
    wr_pxl = 1'b0; wr_pos = 1'b0; wr_mul_reg = 1'b0; wr_wom = 1'b0; wr_mul_pos = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();

    // single wr_wom
    wr_wom = 1'b1; wom_addr = 32'h100; r1 = 32'hDEADBEEF; mem_ready = 1'b1;
    cycle();
    clear_flags();
    #1;
    check("t1_addr", mem_addr, 32'h100);
    check("t1_wdata", mem_wdata, 32'hDEADBEEF);
    check("t1_stall", stall, 0);
    cycle();
    #1 check("t1_idle", busy, 0);

    // burst with a ready gap
    wr_mul_reg = 1'b1; wom_addr = 32'h20; r1 = 1; r2 = 2; r3 = 3; r4 = 4; mem_ready = 1'b1;
    cycle();
    clear_flags();
    hs0 = dut_hs;
    for (int k = 0; k < 5; k++) begin
      mem_ready = pat[k];
      cycle();
    end
    check("t2_beats", dut_hs - hs0, 4);

    // pixel write
    wr_pxl = 1'b1; i = 3; n = 640; j = 5; wom_addr = 32'h1000; r1 = 32'h1234ABCD; mem_ready = 1'b0;
    cycle();
    clear_flags();
    #1;
    check("t3_addr", mem_addr, 32'h1785);
    check("t3_wdata", mem_wdata, 32'hCD);
    mem_ready = 1'b1;
    cycle();

    // burst followed by a wr_wom held under stall
    wr_mul_pos = 1'b1; i = 32'h11; j = 32'h22; n = 32'h33; r1 = 32'h44; wom_addr = 32'h200; mem_ready = 1'b1;
    cycle();
    clear_flags();
    wr_wom = 1'b1; wom_addr = 32'h300; r1 = 32'h55;
    repeat (4) cycle();
    clear_flags();
    #1;
    check("t4_addr", mem_addr, 32'h300);
    check("t4_wdata", mem_wdata, 32'h55);
    cycle();

    // priority + wr_pos, then reset during beat 2
    wr_mul_reg = 1'b1; wr_wom = 1'b1; wr_pos = 1'b1; i = 7; j = 9; wom_addr = 32'h40;
    r1 = 32'hA; r2 = 32'hB; r3 = 32'hC; r4 = 32'hD; mem_ready = 1'b1;
    cycle();
    clear_flags();
    #1;
    check("t5_pos_i", pos_i, 7);
    check("t5_pos_j", pos_j, 9);
    cycle();
    cycle();
    do_reset();
    hs0 = dut_hs;
    repeat (3) cycle();
    check("t5_no_beats", dut_hs - hs0, 0);

`ifdef DRAIN_ADDR_CHECK_EN
    wr_mul_reg = 1'b1; wom_addr = 32'h100; r1 = 1; r2 = 2; r3 = 3; r4 = 4; mem_ready = 1'b1;
    cycle();
    clear_flags();
    hs0 = dut_hs;
    repeat (4) cycle();
    #1;
    check("t6_beats", dut_hs - hs0, 2);
    check("t6_err", err, 1);
    check("t6_busy", busy, 0);
    repeat (2) cycle();
`endif

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      wr_mul_reg = ($urandom_range(0, 5) == 0);
      wr_mul_pos = ($urandom_range(0, 5) == 0);
      wr_wom     = ($urandom_range(0, 5) == 0);
      wr_pxl     = ($urandom_range(0, 5) == 0);
      wr_pos     = ($urandom_range(0, 3) == 0);
      i = $urandom_range(0, 1023);
      j = $urandom_range(0, 1023);
      n = $urandom_range(0, 1023);
      case ($urandom_range(0, 2))
        0:       wom_addr = $urandom;
        1:       wom_addr = 32'hFFFF_FFFE;
        default: wom_addr = $urandom_range(0, 32'h1FF);
      endcase
      r1 = $urandom; r2 = $urandom; r3 = $urandom; r4 = $urandom;
      mem_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle();
    end
    clear_flags();
    mem_ready = 1'b1;
    repeat (6) cycle();
    check("hs_total", dut_hs, exp_hs);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
